// File: rtl/adc_burst_sequencer.sv
// adc_burst_sequencer: runs one ADC acquisition burst per trigger from the
// asynchronous syncro_i. After a programmable start delay it holds the ADC
// request high and captures N_SAMPLES samples, each on a rising edge of the
// ADC ready level. Captured samples go to the averager with valid/last flags.
// Completion, per-sample timeout and triggers while busy are reported as
// single-cycle pulses. All outputs are registered.
module adc_burst_sequencer #(
  parameter int DW        = 12,
  parameter int N_SAMPLES = 8,
  parameter int START_DLY = 11,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          syncro_i,
  output logic          adc_data_req_o,
  input  logic          adc_data_rdy_i,
  input  logic [DW-1:0] adc_data_i,
  output logic [DW-1:0] smp_data_o,
  output logic          smp_valid_o,
  output logic          smp_last_o,
  output logic          burst_done_o,
  output logic          timeout_o,
  output logic          overrun_o,
  output logic          busy_o
);

  // A zero start delay would give a zero-width delay counter, so it keeps one bit.
  localparam int DLY_W  = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;
  localparam int SMP_W  = $clog2(N_SAMPLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam bit NO_DLY = (START_DLY == 0);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic             trig_q, trig_d;
  logic             rdy_z_q, rdy_z_d;
  logic [2:0]       state_q, state_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0]    smp_data_q, smp_data_d;
  logic             smp_valid_q, smp_valid_d;
  logic             smp_last_q, smp_last_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             cap;

  // Synchroniser chain, registered trigger pulse and ready-edge history.
  always_comb begin
    sync1_d = syncro_i;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    trig_d  = sync2_q & ~sync3_q;
    rdy_z_d = adc_data_rdy_i;
    cap     = adc_data_rdy_i & ~rdy_z_q & (state_q == ST_REQ);
  end

  // Burst FSM: next state, counters, sample capture and status pulses.
  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    smp_data_d  = smp_data_q;
    smp_valid_d = 1'b0;
    smp_last_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig_q) begin
          if (NO_DLY) begin
            state_d = ST_REQ;
          end else begin
            state_d   = ST_DELAY;
            dly_cnt_d = DLY_W'(START_DLY);
          end
        end
      end
      ST_DELAY: begin
        if (dly_cnt_q == DLY_W'(1)) begin
          state_d   = ST_REQ;
          dly_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q - DLY_W'(1);
        end
      end
      ST_REQ: begin
        if (cap) begin
          smp_data_d  = adc_data_i;
          smp_valid_d = 1'b1;
          smp_cnt_d   = smp_cnt_q + SMP_W'(1);
          tmo_cnt_d   = '0;
          if (smp_cnt_q == SMP_W'(N_SAMPLES - 1)) begin
            smp_last_d = 1'b1;
            state_d    = ST_DONE;
          end
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_DONE, ST_ERR: begin
        state_d   = ST_IDLE;
        dly_cnt_d = '0;
        smp_cnt_d = '0;
        tmo_cnt_d = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        dly_cnt_d = '0;
        smp_cnt_d = '0;
        tmo_cnt_d = '0;
      end
    endcase

    // Done trails the last sample by one cycle so the averager sees last first;
    // timeout fires on entering ERR, TIMEOUT cycles after the previous capture.
    req_d     = (state_d == ST_REQ);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_DONE);
    timeout_d = (state_d == ST_ERR);
    overrun_d = trig_q & (state_q != ST_IDLE);
  end

  // State and output registers, cleared asynchronously so a reset aborts a burst at once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      trig_q      <= 1'b0;
      rdy_z_q     <= 1'b0;
      state_q     <= ST_IDLE;
      dly_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      smp_data_q  <= '0;
      smp_valid_q <= 1'b0;
      smp_last_q  <= 1'b0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      trig_q      <= trig_d;
      rdy_z_q     <= rdy_z_d;
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      smp_data_q  <= smp_data_d;
      smp_valid_q <= smp_valid_d;
      smp_last_q  <= smp_last_d;
      req_q       <= req_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign adc_data_req_o = req_q;
  assign smp_data_o     = smp_data_q;
  assign smp_valid_o    = smp_valid_q;
  assign smp_last_o     = smp_last_q;
  assign burst_done_o   = done_q;
  assign timeout_o      = timeout_q;
  assign overrun_o      = overrun_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// tb_adc_burst_sequencer: directed bench for adc_burst_sequencer. One instance
// uses the default parameters, a second uses START_DLY=0 / N_SAMPLES=1.
module tb_adc_burst_sequencer;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          syncro, rdy;
  logic [DW-1:0] adc_data;
  logic          req, valid, last, done, tmo, ovr, busy;
  logic [DW-1:0] smp_data;
  logic          syncro1, rdy1;
  logic [DW-1:0] adc_data1;
  logic          req1, valid1, last1, done1, tmo1, ovr1, busy1;
  logic [DW-1:0] smp_data1;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  adc_burst_sequencer #(.DW(DW), .N_SAMPLES(8), .START_DLY(11), .TIMEOUT(255)) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .syncro_i(syncro),
    .adc_data_req_o(req), .adc_data_rdy_i(rdy), .adc_data_i(adc_data),
    .smp_data_o(smp_data), .smp_valid_o(valid), .smp_last_o(last),
    .burst_done_o(done), .timeout_o(tmo), .overrun_o(ovr), .busy_o(busy)
  );

  adc_burst_sequencer #(.DW(DW), .N_SAMPLES(1), .START_DLY(0), .TIMEOUT(255)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .syncro_i(syncro1),
    .adc_data_req_o(req1), .adc_data_rdy_i(rdy1), .adc_data_i(adc_data1),
    .smp_data_o(smp_data1), .smp_valid_o(valid1), .smp_last_o(last1),
    .burst_done_o(done1), .timeout_o(tmo1), .overrun_o(ovr1), .busy_o(busy1)
  );

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One counted comparison with an immediate assertion.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    cmp_cnt++;
    assert (obs === exp_v) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Every output of the default instance is zero.
  task automatic checkIdle0(input string tag);
    checkOutput({tag, "_req"}, 32'(req), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
    checkOutput({tag, "_last"}, 32'(last), 32'd0);
    checkOutput({tag, "_data"}, 32'(smp_data), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_tmo"}, 32'(tmo), 32'd0);
    checkOutput({tag, "_ovr"}, 32'(ovr), 32'd0);
  endtask

  // Trigger the default instance; req must rise 15 edges after syncro goes high.
  task automatic startBurst();
    syncro = 1'b1;
    step(2);
    syncro = 1'b0;
    step(1);
    checkOutput("busy_before_trig_used", 32'(busy), 32'd0);
    step(1);
    checkOutput("busy_in_delay", 32'(busy), 32'd1);
    step(10);
    checkOutput("req_before_delay_end", 32'(req), 32'd0);
    step(1);
    checkOutput("req_rise", 32'(req), 32'd1);
  endtask

  // One ready pulse, 2 cycles high and 3 low, with the checks around it.
  task automatic applyStimulus(input logic [DW-1:0] d, input bit exp_last);
    adc_data = d;
    rdy      = 1'b1;
    step(1);
    checkOutput("smp_valid", 32'(valid), 32'd1);
    checkOutput("smp_data", 32'(smp_data), 32'(d));
    checkOutput("smp_last", 32'(last), 32'(exp_last));
    checkOutput("req_after_cap", 32'(req), exp_last ? 32'd0 : 32'd1);
    step(1);
    checkOutput("valid_rdy_held", 32'(valid), 32'd0);
    checkOutput("burst_done", 32'(done), 32'(exp_last));
    rdy = 1'b0;
    step(1);
    checkOutput("done_cleared", 32'(done), 32'd0);
    step(2);
  endtask

  initial begin
    reset_n   = 1'b0;
    syncro    = 1'b0;
    rdy       = 1'b0;
    adc_data  = '0;
    syncro1   = 1'b0;
    rdy1      = 1'b0;
    adc_data1 = '0;
    #2;
    checkIdle0("reset");
    checkOutput("reset_req1", 32'(req1), 32'd0);
    checkOutput("reset_busy1", 32'(busy1), 32'd0);
    #10;
    reset_n = 1'b1;
    step(2);

    $display("[TB] burst with default timing");
    startBurst();
    for (int i = 0; i < 8; i++) applyStimulus(12'h100 + 12'(i), i == 7);
    checkOutput("busy_after_burst", 32'(busy), 32'd0);

    $display("[TB] ready stops after three samples");
    startBurst();
    for (int i = 0; i < 3; i++) applyStimulus(12'h180 + 12'(i), 1'b0);
    step(250);
    checkOutput("timeout_early", 32'(tmo), 32'd0);
    checkOutput("req_before_timeout", 32'(req), 32'd1);
    step(1);
    checkOutput("timeout_pulse", 32'(tmo), 32'd1);
    checkOutput("req_dropped", 32'(req), 32'd0);
    checkOutput("no_done_on_timeout", 32'(done), 32'd0);
    checkOutput("no_last_on_timeout", 32'(last), 32'd0);
    step(1);
    checkOutput("timeout_single", 32'(tmo), 32'd0);
    checkOutput("busy_after_timeout", 32'(busy), 32'd0);
    checkOutput("no_done_after_timeout", 32'(done), 32'd0);

    $display("[TB] trigger during sampling");
    startBurst();
    for (int i = 0; i < 2; i++) applyStimulus(12'h200 + 12'(i), 1'b0);
    syncro = 1'b1;
    step(2);
    syncro = 1'b0;
    step(1);
    checkOutput("overrun_early", 32'(ovr), 32'd0);
    step(1);
    checkOutput("overrun_pulse", 32'(ovr), 32'd1);
    checkOutput("req_kept_on_overrun", 32'(req), 32'd1);
    step(1);
    checkOutput("overrun_single", 32'(ovr), 32'd0);
    for (int i = 2; i < 8; i++) applyStimulus(12'h200 + 12'(i), i == 7);

    $display("[TB] ready high before request");
    rdy = 1'b1;
    startBurst();
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput("no_sample_on_held_rdy", 32'(valid), 32'd0);
    end
    rdy = 1'b0;
    step(1);
    checkOutput("no_sample_on_fall", 32'(valid), 32'd0);
    adc_data = 12'h300;
    rdy      = 1'b1;
    step(1);
    checkOutput("first_sample_valid", 32'(valid), 32'd1);
    checkOutput("first_sample_data", 32'(smp_data), 32'h300);
    for (int i = 0; i < 8; i++) begin
      step(1);
      checkOutput("held_level_once", 32'(valid), 32'd0);
    end
    rdy = 1'b0;
    step(3);
    for (int i = 1; i < 8; i++) applyStimulus(12'h300 + 12'(i), i == 7);

    $display("[TB] reset during sampling");
    startBurst();
    for (int i = 0; i < 4; i++) applyStimulus(12'h400 + 12'(i), 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    checkIdle0("async_reset");
    #12;
    reset_n = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("no_done_after_reset", 32'(done), 32'd0);
      checkOutput("no_timeout_after_reset", 32'(tmo), 32'd0);
      checkOutput("idle_after_reset", 32'(busy), 32'd0);
      step(1);
    end
    startBurst();
    for (int i = 0; i < 8; i++) applyStimulus(12'h500 + 12'(i), i == 7);

    $display("[TB] zero delay, single sample");
    syncro1 = 1'b1;
    step(2);
    syncro1 = 1'b0;
    step(1);
    checkOutput("z_req_before", 32'(req1), 32'd0);
    step(1);
    checkOutput("z_req_rise", 32'(req1), 32'd1);
    checkOutput("z_busy", 32'(busy1), 32'd1);
    adc_data1 = 12'hABC;
    rdy1      = 1'b1;
    step(1);
    checkOutput("z_valid", 32'(valid1), 32'd1);
    checkOutput("z_last", 32'(last1), 32'd1);
    checkOutput("z_data", 32'(smp_data1), 32'hABC);
    checkOutput("z_req_fall", 32'(req1), 32'd0);
    step(1);
    checkOutput("z_done", 32'(done1), 32'd1);
    checkOutput("z_no_timeout", 32'(tmo1), 32'd0);
    checkOutput("z_no_overrun", 32'(ovr1), 32'd0);
    rdy1 = 1'b0;
    step(1);
    checkOutput("z_done_single", 32'(done1), 32'd0);
    checkOutput("z_idle", 32'(busy1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
